// File: rtl/fir_pkg.sv
// Shared types and helpers for the polyphase FIR interpolator.
package fir_pkg;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   // Width of the intermediate used by round_sat; wide enough for any sane IW/CW/TPP.
   localparam int RS_W = 64;

   // Accumulator width: full product plus headroom for summing tpp products.
   function automatic int acc_width(input int iw, input int cw, input int tpp);
      return iw + cw + $clog2(tpp);
   endfunction

   // Round half toward +inf, drop the Q1.(cw-1) fraction, clip to iw bits.
   // Returns {clip, value}; value is sign-extended to RS_W bits.
   function automatic logic [RS_W:0] round_sat(input logic signed [RS_W-1:0] acc,
                                               input int iw, input int cw);
      logic signed [RS_W-1:0] r;
      logic signed [RS_W-1:0] hi;
      logic signed [RS_W-1:0] lo;
      r  = (acc + (64'sd1 <<< (cw - 2))) >>> (cw - 1);
      hi = (64'sd1 <<< (iw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (iw - 1));
      if (r > hi) return {1'b1, hi};
      if (r < lo) return {1'b1, lo};
      return {1'b0, r};
   endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate; the sum output exposes acc + current product so the
// final tap can be rounded on the same edge it is accumulated.
module fir_mac #(
   parameter int IW = 16,
   parameter int CW = 16,
   parameter int AW = 35
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clr,
   input  logic                 en,
   input  logic signed [IW-1:0] a,
   input  logic signed [CW-1:0] b,
   output logic signed [AW-1:0] sum
);

   logic signed [IW+CW-1:0] prod;
   logic signed [AW-1:0]    acc;

   assign prod = a * b;
   assign sum  = acc + AW'(prod);

   // Accumulator register: clear between phases, add one product per enabled cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)    acc <= '0;
      else if (clr) acc <= '0;
      else if (en)  acc <= sum;
   end

endmodule

// File: rtl/fir_interpolator.sv
// Polyphase FIR interpolator: one input sample produces L outputs, each the dot
// product of the TPP-deep delay line with one phase of the prototype filter.
module fir_interpolator
   import fir_pkg::*;
#(
   parameter int IW  = 16,
   parameter int CW  = 16,
   parameter int L   = 4,
   parameter int TPP = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CW*L*TPP-1:0]   coefficients,
   input  logic [IW-1:0]         in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [IW-1:0]         out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  sat_flag
);

   localparam int AW = acc_width(IW, CW, TPP);
   localparam int NT = L * TPP;
   localparam int PW = (L > 1) ? $clog2(L) : 1;
   localparam int JW = (TPP > 1) ? $clog2(TPP) : 1;
   localparam int KW = (NT > 1) ? $clog2(NT) : 1;

   state_t               state;
   logic [PW-1:0]        phase;
   logic [JW-1:0]        j;
   logic signed [IW-1:0] x [TPP];

   logic signed [CW-1:0] h [NT];
   logic [KW-1:0]        k_idx;
   logic signed [AW-1:0] mac_sum;
   logic                 mac_clr;
   logic                 mac_en;
   logic                 last_phase;
   logic [RS_W:0]        rs;
   logic                 rs_unused;

   // Unpack the flat prototype into h[k].
   for (genvar k = 0; k < NT; k++) begin : g_coef
      assign h[k] = coefficients[k*CW +: CW];
   end

   // Tap j of phase p uses prototype coefficient h[p + L*j].
   assign k_idx      = KW'(phase) + KW'(L) * KW'(j);
   assign last_phase = (phase == PW'(L - 1));

   // Clear the accumulator on every phase start; accumulate only while in MAC.
   always_comb begin
      mac_clr = 1'b0;
      mac_en  = 1'b0;
      if (state == IDLE && in_valid)                  mac_clr = 1'b1;
      if (state == OUT && out_ready && !last_phase)   mac_clr = 1'b1;
      if (state == MAC)                               mac_en  = 1'b1;
   end

   fir_mac #(.IW(IW), .CW(CW), .AW(AW)) u_mac (
      .clk   (clk),
      .reset (reset),
      .clr   (mac_clr),
      .en    (mac_en),
      .a     (x[j]),
      .b     (h[k_idx]),
      .sum   (mac_sum)
   );

   assign rs = round_sat(RS_W'(mac_sum), IW, CW);
   // After saturation the value fits in IW bits; the rest is sign extension.
   assign rs_unused = ^rs[RS_W-1:IW];

   // Control FSM, delay line and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         phase     <= '0;
         j         <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         sat_flag  <= 1'b0;
         in_ready  <= 1'b1;
         for (int i = 0; i < TPP; i++) x[i] <= '0;
      end else begin
         sat_flag <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  for (int i = TPP - 1; i > 0; i--) x[i] <= x[i-1];
                  x[0]     <= in_data;
                  phase    <= '0;
                  j        <= '0;
                  in_ready <= 1'b0;
                  state    <= MAC;
               end
            end
            MAC: begin
               j <= j + 1'b1;
               if (j == JW'(TPP - 1)) begin
                  j         <= '0;
                  out_data  <= rs[IW-1:0];
                  sat_flag  <= rs[RS_W];
                  out_valid <= 1'b1;
                  state     <= OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (!last_phase) begin
                     phase <= phase + 1'b1;
                     j     <= '0;
                     state <= MAC;
                  end else begin
                     in_ready <= 1'b1;
                     state    <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_interpolator.sv
// Bench for fir_interpolator: a direct-form polyphase model predicts every output,
// a negedge monitor checks each one, and directed tests pin literal values.
module tb_fir_interpolator;

   localparam int IW  = 16;
   localparam int CW  = 16;
   localparam int L   = 4;
   localparam int TPP = 8;
   localparam int NT  = L * TPP;

   typedef struct {
      longint val;
      bit     sat;
   } exp_t;

   logic                clk = 1'b0;
   logic                reset;
   logic [CW*NT-1:0]    coefficients;
   logic [IW-1:0]       in_data;
   logic                in_valid;
   logic                in_ready;
   logic [IW-1:0]       out_data;
   logic                out_valid;
   logic                out_ready;
   logic                sat_flag;

   int     nvec = 0;
   int     nerr = 0;
   int     cyc  = 0;
   int     acc_cyc;
   int     h  [NT];
   int     xs [TPP];
   exp_t   expq [$];
   longint got [$];
   bit     gots [$];
   int     gotcyc [$];
   bit     fresh = 1'b1;
   longint held;

   fir_interpolator #(.IW(IW), .CW(CW), .L(L), .TPP(TPP)) dut (
      .clk          (clk),
      .reset        (reset),
      .coefficients (coefficients),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .sat_flag     (sat_flag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // y_p = floor((sum_j x[j]*h[p+L*j] + 2^14) / 2^15), clipped to 16 bits.
   function automatic void push_sample(input int s);
      longint acc;
      longint q;
      exp_t   e;
      for (int i = TPP - 1; i > 0; i--) xs[i] = xs[i-1];
      xs[0] = s;
      for (int p = 0; p < L; p++) begin
         acc = 0;
         for (int t = 0; t < TPP; t++) acc += longint'(xs[t]) * longint'(h[p + L*t]);
         acc += 16384;
         q = acc / 32768;
         if (acc < 0 && (acc % 32768) != 0) q -= 1;
         e.sat = 1'b0;
         if (q > 32767)       begin q = 32767;  e.sat = 1'b1; end
         else if (q < -32768) begin q = -32768; e.sat = 1'b1; end
         e.val = q;
         expq.push_back(e);
      end
   endfunction

   task automatic load_coefs();
      for (int k = 0; k < NT; k++) coefficients[k*CW +: CW] = CW'(h[k]);
   endtask

   task automatic set_impulse_coefs();
      for (int k = 0; k < NT; k++) h[k] = 0;
      h[0] = 16384;
      h[5] = 8192;
      load_coefs();
   endtask

   task automatic send(input int s, input bit keep);
      int n;
      n = 0;
      in_data  = IW'(s);
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      push_sample(s);
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      while (!(expq.size() == 0 && in_ready && !out_valid) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) chk("drain_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   // Monitor: each new output is checked against the model; stalls must hold.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         expq.delete();
         fresh = 1'b1;
      end else if (out_valid) begin
         if (fresh) begin
            if (expq.size() == 0) begin
               chk("unexpected_output", 1, 0);
               held = 0;
            end else begin
               e = expq.pop_front();
               chk("out_data", longint'($signed(out_data)), e.val);
               chk("sat_flag", longint'(sat_flag), longint'(e.sat));
               held = e.val;
            end
            got.push_back(longint'($signed(out_data)));
            gots.push_back(sat_flag);
            gotcyc.push_back(cyc);
            fresh = 1'b0;
         end else begin
            chk("hold_data", longint'($signed(out_data)), held);
            chk("sat_pulse_len", longint'(sat_flag), 0);
         end
         chk("in_ready_busy", longint'(in_ready), 0);
         if (out_ready) fresh = 1'b1;
      end
   end

   initial begin
      int base;
      int t0, t1, t2, t3;
      int n;

      reset        = 1'b1;
      in_valid     = 1'b0;
      in_data      = '0;
      out_ready    = 1'b1;
      coefficients = '0;
      for (int k = 0; k < NT; k++) h[k] = 0;
      for (int i = 0; i < TPP; i++) xs[i] = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_data",  longint'(out_data), 0);
      chk("rst_in_ready",  longint'(in_ready), 1);
      chk("rst_sat_flag",  longint'(sat_flag), 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Impulse through a two-tap prototype
      set_impulse_coefs();
      base = got.size();
      send(16384, 0);
      repeat (3) send(0, 0);
      drain();
      for (int i = 0; i < 16; i++)
         chk($sformatf("impulse_%0d", i), got[base+i], (i == 0) ? 8192 : (i == 5) ? 4096 : 0);

      // Rounding at the half-LSB boundary
      for (int k = 0; k < NT; k++) h[k] = 0;
      h[0] = 1;
      load_coefs();
      base = got.size();
      send(16384, 0);
      send(-16384, 0);
      send(16383, 0);
      drain();
      chk("round_pos_half", got[base], 1);
      chk("round_neg_half", got[base+4], 0);
      chk("round_below_half", got[base+8], 0);

      // Saturation in both directions
      for (int k = 0; k < NT; k++) h[k] = 32767;
      load_coefs();
      repeat (8) send(32767, 0);
      drain();
      chk("sat_pos_val", got[got.size()-1], 32767);
      chk("sat_pos_flag", longint'(gots[gots.size()-1]), 1);
      repeat (8) send(-32768, 0);
      drain();
      chk("sat_neg_val", got[got.size()-1], -32768);
      chk("sat_neg_flag", longint'(gots[gots.size()-1]), 1);
      repeat (8) send(0, 0);
      drain();
      chk("zero_val", got[got.size()-1], 0);
      chk("zero_flag", longint'(gots[gots.size()-1]), 0);

      // Backpressure: hold the first output for 10 cycles
      set_impulse_coefs();
      base = got.size();
      out_ready = 1'b0;
      send(16384, 0);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) chk("bp_valid_timeout", 0, 1);
      repeat (10) begin
         chk("bp_out_valid", longint'(out_valid), 1);
         chk("bp_out_data", longint'($signed(out_data)), 8192);
         chk("bp_in_ready", longint'(in_ready), 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(0, 0);
      send(0, 0);
      drain();
      chk("bp_output_count", got.size() - base, 12);
      chk("bp_first", got[base], 8192);
      chk("bp_fifth", got[base+5], 4096);

      // Timing with in_valid held high
      base = got.size();
      send(100, 1);  t0 = acc_cyc;
      send(200, 1);  t1 = acc_cyc;
      send(-300, 1); t2 = acc_cyc;
      send(0, 0);    t3 = acc_cyc;
      drain();
      chk("accept_period_1", t1 - t0, 37);
      chk("accept_period_2", t2 - t1, 37);
      chk("accept_period_3", t3 - t2, 37);
      chk("first_latency", gotcyc[base] - t0, 8);
      chk("timing_count", got.size() - base, 16);

      // Reset in the middle of phase 2
      base = got.size();
      send(1234, 0);
      n = 0;
      while (got.size() < base + 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (got.size() < base + 2) chk("phase2_timeout", 0, 1);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", longint'(out_valid), 0);
      chk("midrst_out_data", longint'(out_data), 0);
      chk("midrst_in_ready", longint'(in_ready), 1);
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < TPP; i++) xs[i] = 0;
      base = got.size();
      send(16384, 0);
      repeat (3) send(0, 0);
      drain();
      for (int i = 0; i < 16; i++)
         chk($sformatf("post_rst_%0d", i), got[base+i], (i == 0) ? 8192 : (i == 5) ? 4096 : 0);
      chk("queue_empty", expq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
